// File: rtl/mem_port_arbiter.sv
// Memory-port arbiter between instruction fetch (I) and data access (D) with req/ready sequencing and timeout.
// Optional feature macro: ROUND_ROBIN_EN (alternate owner on ties); default build gives D fixed priority.
module mem_port_arbiter #(
    parameter int unsigned MAX_WAIT  = 15,
    parameter int unsigned CNT_WIDTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic req_i,
    input  logic req_d,
    input  logic we_d,
    input  logic mem_ready,
    output logic mem_req,
    output logic mem_we,
    output logic sel,
    output logic gnt_i,
    output logic gnt_d,
    output logic done_i,
    output logic done_d,
    output logic err
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(MAX_WAIT - 1);

    state_t               state;
    logic [CNT_WIDTH-1:0] wait_cnt;
    logic                 pick_d;
    logic                 timeout;

`ifdef ROUND_ROBIN_EN
    logic last_owner;  // 0 = I, 1 = D

    // Tie goes to whichever requester was not granted last.
    always_comb begin
        pick_d = req_d;
        if (req_i && req_d) begin
            pick_d = (last_owner == 1'b0);
        end
    end
`else
    // D wins ties so a stalled load/store cannot be starved by fetch.
    always_comb begin
        pick_d = req_d;
    end
`endif

    assign timeout = (MAX_WAIT != 0) && (wait_cnt == LAST_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            sel      <= 1'b0;
            gnt_i    <= 1'b0;
            gnt_d    <= 1'b0;
            done_i   <= 1'b0;
            done_d   <= 1'b0;
            err      <= 1'b0;
`ifdef ROUND_ROBIN_EN
            last_owner <= 1'b0;
`endif
        end else begin
            done_i <= 1'b0;
            done_d <= 1'b0;
            err    <= 1'b0;
            case (state)
                IDLE: begin
                    // sel is left alone here so the address mux stays stable between accesses.
                    if (req_i || req_d) begin
                        state    <= ACCESS;
                        gnt_i    <= ~pick_d;
                        gnt_d    <= pick_d;
                        mem_req  <= 1'b1;
                        sel      <= pick_d;
                        mem_we   <= pick_d & we_d;
                        wait_cnt <= '0;
`ifdef ROUND_ROBIN_EN
                        last_owner <= pick_d;
`endif
                    end
                end
                ACCESS: begin
                    // mem_ready takes precedence over a coincident timeout.
                    if (mem_ready) begin
                        state   <= IDLE;
                        done_i  <= gnt_i;
                        done_d  <= gnt_d;
                        gnt_i   <= 1'b0;
                        gnt_d   <= 1'b0;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                    end else if (timeout) begin
                        state   <= IDLE;
                        err     <= 1'b1;
                        gnt_i   <= 1'b0;
                        gnt_d   <= 1'b0;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_WIDTH'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
